wave_ram_ctrl: RTL and testbench

//  Owns the single-port waveform RAM of the arbitrary wave generator.

---
 rtl/wave_ram_ctrl_if.sv | 40 ++++
 rtl/wave_ram_ctrl.sv | 99 +++++++++
 tb/tb_wave_ram_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/wave_ram_ctrl_if.sv
// Bundle for the wave RAM controller: Initializer stream, playback, host bus and RAM port.
interface wave_ram_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9
);
  logic [DATA_W-1:0] init_data;
  logic              init_data_v;
  logic              init_done;
  logic              play_req;
  logic [ADDR_W-1:0] play_addr;
  logic [DATA_W-1:0] play_data;
  logic              play_data_v;
  logic              host_v;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_rdy;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rdata_v;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              running;
  logic              init_ovf;

  modport slave (
    input  init_data, init_data_v, init_done, play_req, play_addr,
           host_v, host_we, host_addr, host_wdata, ram_rdata,
    output play_data, play_data_v, host_rdy, host_rdata, host_rdata_v,
           ram_addr, ram_wdata, ram_we, running, init_ovf
  );

  modport master (
    output init_data, init_data_v, init_done, play_req, play_addr,
           host_v, host_we, host_addr, host_wdata, ram_rdata,
    input  play_data, play_data_v, host_rdy, host_rdata, host_rdata_v,
           ram_addr, ram_wdata, ram_we, running, init_ovf
  );
endinterface

// File: rtl/wave_ram_ctrl.sv
// Waveform RAM owner: boot fill from the Initializer, then playback-priority sharing with the host.
// Optional host read-back path enabled by defining HOST_RD_EN.
module wave_ram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  wave_ram_ctrl_if.slave bus
);
  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]      state;
  logic [ADDR_W:0] fill_cnt;
  logic            run, play_g, host_g, host_wr, host_rd, fill_we;
  logic            rd_play_q;

  assign run         = (state == S_RUN);
  assign bus.running = run;
  assign bus.host_rdy = run & ~bus.play_req;

  always_comb begin
    play_g  = run & bus.play_req;
    host_g  = bus.host_v & bus.host_rdy;
`ifdef HOST_RD_EN
    host_wr = host_g & bus.host_we;
    host_rd = host_g & ~bus.host_we;
`else
    host_wr = host_g;
    host_rd = 1'b0;
`endif
    // fill counter MSB set means the RAM is full; rst_n gating keeps ram_we low during reset
    fill_we = rst_n & ~run & bus.init_data_v & ~fill_cnt[ADDR_W];
  end

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_we    = 1'b0;
    if (fill_we) begin
      bus.ram_addr  = fill_cnt[ADDR_W-1:0];
      bus.ram_wdata = bus.init_data;
      bus.ram_we    = 1'b1;
    end else if (play_g) begin
      bus.ram_addr  = bus.play_addr;
    end else if (host_g) begin
      bus.ram_addr  = bus.host_addr;
      bus.ram_wdata = bus.host_wdata;
      bus.ram_we    = host_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_INIT;
      fill_cnt     <= '0;
      bus.init_ovf <= 1'b0;
    end else if (!run) begin
      if (fill_we) fill_cnt <= fill_cnt + 1'b1;
      if (bus.init_data_v && fill_cnt[ADDR_W]) bus.init_ovf <= 1'b1;
      if (bus.init_done && !bus.init_data_v) state <= S_RUN;
    end
  end

  // RAM read data lags the address by one cycle; capture it into the owner's output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_play_q       <= 1'b0;
      bus.play_data_v <= 1'b0;
      bus.play_data   <= {DATA_W{1'b0}};
    end else begin
      rd_play_q       <= play_g;
      bus.play_data_v <= rd_play_q;
      if (rd_play_q) bus.play_data <= bus.ram_rdata;
    end
  end

`ifdef HOST_RD_EN
  logic rd_host_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_host_q        <= 1'b0;
      bus.host_rdata_v <= 1'b0;
      bus.host_rdata   <= {DATA_W{1'b0}};
    end else begin
      rd_host_q        <= host_rd;
      bus.host_rdata_v <= rd_host_q;
      if (rd_host_q) bus.host_rdata <= bus.ram_rdata;
    end
  end
`else
  logic unused_host_rd;
  assign unused_host_rd   = &{1'b0, host_rd, bus.host_we};
  assign bus.host_rdata   = {DATA_W{1'b0}};
  assign bus.host_rdata_v = 1'b0;
`endif
endmodule

// File: tb/tb_wave_ram_ctrl.sv
// Directed bench for wave_ram_ctrl with a behavioural registered-read RAM.
module tb_wave_ram_ctrl;
  localparam int AW = 8;
  localparam int DW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  wave_ram_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  wave_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic stream(input int n, input logic [DW-1:0] xr);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.init_data_v = 1'b1;
      bus.init_data   = DW'(k) ^ xr;
      #1;
      if (k < 3 || k == 255) begin
        chk("fill_we", bus.ram_we, (k < 256) ? 1 : 0);
        chk("fill_addr", bus.ram_addr, k & 8'hFF);
      end
      if (k == 256) chk("sat_we", bus.ram_we, 0);
    end
    @(negedge clk);
    bus.init_data_v = 1'b0;
  endtask

  task automatic go_run();
    bus.init_done = 1'b1;
    #1 chk("run_lag", bus.running, 0);
    @(negedge clk);
    #1 chk("running", bus.running, 1);
  endtask

  initial begin
    int e;
    bus.init_data = '0; bus.init_data_v = 1'b0; bus.init_done = 1'b0;
    bus.play_req = 1'b0; bus.play_addr = '0;
    bus.host_v = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.init_data_v = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_we", bus.ram_we, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_pdv", bus.play_data_v, 0);
    chk("rst_pd", bus.play_data, 0);
    chk("rst_rdy", bus.host_rdy, 0);
    chk("rst_hrv", bus.host_rdata_v, 0);
    chk("rst_hrd", bus.host_rdata, 0);
    chk("rst_run", bus.running, 0);
    chk("rst_ovf", bus.init_ovf, 0);
    bus.init_data_v = 1'b0;
    rst_n = 1'b1;

    // full fill, then run
    stream(256, 9'h0AA);
    go_run();
    chk("t1_ovf", bus.init_ovf, 0);
    chk("t1_rdy", bus.host_rdy, 1);
    e = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== (DW'(a) ^ 9'h0AA)) e++;
    chk("t1_mem", e, 0);

    // back-to-back playback, latency 2
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      bus.play_req  = (i < 16);
      bus.play_addr = AW'(i);
      #1;
      if (i < 16) chk("t3_rdy", bus.host_rdy, 0);
      if (i < 2 || i == 18) chk("t3_pdv0", bus.play_data_v, 0);
      else begin
        chk("t3_pdv", bus.play_data_v, 1);
        chk("t3_pd", bus.play_data, DW'(i - 2) ^ 9'h0AA);
      end
    end
    chk("t3_hold", bus.play_data, 9'h0A5);

    // host write stalled by three playback cycles
    bus.host_v = 1'b1; bus.host_we = 1'b1; bus.host_addr = 8'h10; bus.host_wdata = 9'h1FF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.play_req  = (i < 3);
      bus.play_addr = AW'(8'h20 + i);
      #1;
      chk("t4_rdy", bus.host_rdy, (i == 3) ? 1 : 0);
      chk("t4_we", bus.ram_we, (i == 3) ? 1 : 0);
      if (i == 3) chk("t4_addr", bus.ram_addr, 8'h10);
      if (i == 2) chk("t4_pd", bus.play_data, 9'h0AA ^ 9'h020);
    end
    @(negedge clk);
    bus.host_v = 1'b0; bus.init_data_v = 1'b1;
    bus.play_req = 1'b1; bus.play_addr = 8'h10;
    #1 chk("t4_initign", bus.ram_we, 0);
    @(negedge clk);
    bus.play_req = 1'b0; bus.init_data_v = 1'b0;
    @(negedge clk);
    #1 chk("t4_rb", bus.play_data, 9'h1FF);

    // overflow: 260 samples, no wrap
    rst_n = 1'b0; bus.init_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stream(260, 9'h155);
    #1;
    chk("t2_ovf", bus.init_ovf, 1);
    chk("t2_mem0", mem[0], 9'h155);
    chk("t2_mem255", mem[255], 9'h1AA);
    chk("t2_run", bus.running, 0);
    rst_n = 1'b0;
    #1 chk("t2_ovf_clr", bus.init_ovf, 0);

    // reset mid-fill, restart from address 0
    @(negedge clk);
    rst_n = 1'b1;
    stream(100, 9'h0AA);
    bus.init_data_v = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_we", bus.ram_we, 0);
    chk("t5_addr", bus.ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1; bus.init_data_v = 1'b0;
    stream(8, 9'h0C0);
    chk("t5_mem0", mem[0], 9'h0C0);
    chk("t5_mem5", mem[5], 9'h0C5);
    chk("t5_mem8", mem[8], 9'h0AA ^ 9'h008);
    go_run();

    // host access with host_we=0
    @(negedge clk);
    bus.host_v = 1'b1; bus.host_we = 1'b0; bus.host_addr = 8'h05; bus.host_wdata = 9'h123;
    #1;
    chk("t6_rdy", bus.host_rdy, 1);
`ifdef HOST_RD_EN
    chk("t6_we", bus.ram_we, 0);
`else
    chk("t6_we", bus.ram_we, 1);
`endif
    @(negedge clk);
    bus.host_v = 1'b0;
    #1 chk("t6_hrv_early", bus.host_rdata_v, 0);
    @(negedge clk);
    #1;
`ifdef HOST_RD_EN
    chk("t6_hrv", bus.host_rdata_v, 1);
    chk("t6_hrd", bus.host_rdata, 9'h0C5);
    chk("t6_pdv", bus.play_data_v, 0);
`else
    chk("t6_hrv", bus.host_rdata_v, 0);
    chk("t6_mem5", mem[5], 9'h123);
`endif
    @(negedge clk);
    #1 chk("t6_hrv_end", bus.host_rdata_v, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
